// File: rtl/armleocpu_tlb_sa.sv
// Set-associative TLB: per-set round-robin replacement, single-cycle lookup,
// per-VPN invalidate, and a sequential whole-table flush (one set per cycle).
module armleocpu_tlb_sa #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        resolve,
  input  logic [19:0] virtual_address,
  input  logic        write,
  input  logic [19:0] virtual_address_w,
  input  logic [7:0]  accesstag_w,
  input  logic [21:0] phys_w,
  input  logic        invalidate,
  input  logic        invalidate_va,
  output logic        done,
  output logic        miss,
  output logic [7:0]  accesstag_r,
  output logic [21:0] phys_r,
  output logic        busy
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int WAYS  = 1 << WAYS_W;
  localparam int TAG_W = 20 - ENTRIES_W;
  // Way index needs at least one bit even for a direct-mapped table
  localparam int WI_W  = (WAYS_W < 1) ? 1 : WAYS_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [ENTRIES_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic                   valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]       tag_q    [SETS][WAYS];
  logic [7:0]             atag_q   [SETS][WAYS];
  logic [21:0]            ppn_q    [SETS][WAYS];
  logic [WI_W-1:0]        victim_q [SETS];

  logic [ENTRIES_W-1:0]   r_set, w_set;
  logic [TAG_W-1:0]       r_tag, w_tag;
  logic                   r_hit;
  logic [7:0]             r_atag;
  logic [21:0]            r_ppn;
  logic [WAYS-1:0]        w_hit_vec;
  logic                   w_match, w_free, w_bump;
  logic [WI_W-1:0]        w_match_way, w_free_way, w_way, victim_nxt;
  logic                   accept;

  assign busy   = (state_q == FLUSH);
  assign accept = resolve && !busy;
  assign r_set  = virtual_address[ENTRIES_W-1:0];
  assign r_tag  = virtual_address[19:ENTRIES_W];
  assign w_set  = virtual_address_w[ENTRIES_W-1:0];
  assign w_tag  = virtual_address_w[19:ENTRIES_W];

  // Lookup: descending scan so the lowest matching way wins
  always_comb begin
    r_hit  = 1'b0;
    r_atag = 8'h00;
    r_ppn  = 22'h0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[r_set][i] && tag_q[r_set][i] == r_tag) begin
        r_hit  = 1'b1;
        r_atag = atag_q[r_set][i];
        r_ppn  = ppn_q[r_set][i];
      end
    end
  end

  // Fill-way selection: matching way, else lowest invalid way, else victim
  always_comb begin
    w_hit_vec   = '0;
    w_match     = 1'b0;
    w_free      = 1'b0;
    w_match_way = '0;
    w_free_way  = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[w_set][i] && tag_q[w_set][i] == w_tag) begin
        w_hit_vec[i] = 1'b1;
        w_match      = 1'b1;
        w_match_way  = WI_W'(i);
      end
      if (!valid_q[w_set][i]) begin
        w_free     = 1'b1;
        w_free_way = WI_W'(i);
      end
    end
    w_bump     = !w_match && !w_free;
    w_way      = w_match ? w_match_way : (w_free ? w_free_way : victim_q[w_set]);
    victim_nxt = (WAYS_W == 0) ? '0 : victim_q[w_set] + 1'b1;
  end

  // Flush FSM next-state: sweep sets 0..SETS-1, counter wraps on exit
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (invalidate) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == ENTRIES_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  // FSM state register; reset (re)starts a flush from set 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Table update: flush > invalidate > invalidate_va > write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == FLUSH) begin
        for (int i = 0; i < WAYS; i++) valid_q[flush_cnt_q][i] <= 1'b0;
        victim_q[flush_cnt_q] <= '0;
      end else if (invalidate) begin
        // flush begins next cycle; nothing else lands this cycle
      end else if (invalidate_va) begin
        for (int i = 0; i < WAYS; i++)
          if (w_hit_vec[i]) valid_q[w_set][i] <= 1'b0;
      end else if (write) begin
        valid_q[w_set][w_way] <= 1'b1;
        tag_q[w_set][w_way]   <= w_tag;
        atag_q[w_set][w_way]  <= accesstag_w;
        ppn_q[w_set][w_way]   <= phys_w;
        if (w_bump) victim_q[w_set] <= victim_nxt;
      end
    end
  end

  // Lookup response register: one-cycle done pulse with result
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      miss        <= 1'b0;
      accesstag_r <= 8'h00;
      phys_r      <= 22'h0;
    end else begin
      done <= accept;
      if (accept) begin
        if (!enable) begin
          miss        <= 1'b0;
          accesstag_r <= 8'h00;
          phys_r      <= {2'b00, virtual_address};
        end else begin
          miss        <= !r_hit;
          accesstag_r <= r_atag;
          phys_r      <= r_ppn;
        end
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_tlb_sa.sv
// Directed bench for armleocpu_tlb_sa with default geometry (16 sets, 2 ways).
module tb_armleocpu_tlb_sa;

  logic        clk = 1'b0;
  logic        rst, enable, resolve, write, invalidate, invalidate_va;
  logic [19:0] virtual_address, virtual_address_w;
  logic [7:0]  accesstag_w, accesstag_r;
  logic [21:0] phys_w, phys_r;
  logic        done, miss, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  armleocpu_tlb_sa dut (
    .clk(clk), .rst(rst), .enable(enable), .resolve(resolve),
    .virtual_address(virtual_address), .write(write),
    .virtual_address_w(virtual_address_w), .accesstag_w(accesstag_w),
    .phys_w(phys_w), .invalidate(invalidate), .invalidate_va(invalidate_va),
    .done(done), .miss(miss), .accesstag_r(accesstag_r), .phys_r(phys_r),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one lookup, return the packed {done,miss,accesstag_r,phys_r}
  task automatic lookup(input logic [19:0] va, input logic en, output logic [31:0] res);
    enable = en;
    virtual_address = va;
    resolve = 1'b1;
    tick();
    res = {done, miss, accesstag_r, phys_r};
    resolve = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] va, input logic [7:0] at, input logic [21:0] pp);
    virtual_address_w = va;
    accesstag_w = at;
    phys_w = pp;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  // Count cycles busy stays high (bounded), optionally pulsing invalidate mid-way
  task automatic busy_len(input int pulse_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      invalidate = (n == pulse_at);
      tick();
    end
    invalidate = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] res;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, miss, accesstag_r, phys_r} !== {1'b1, 1'b0, 1'b0, 8'h00, 22'h0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {busy, done, miss, accesstag_r, phys_r}, {1'b1, 32'h0});
    end
    n = 0;
    enable = 1'b1;
    virtual_address = 20'h20000;
    resolve = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL busy_drop_resolve cycle=%0d got=%b want=0", n, done);
      end
      tick();
    end
    resolve = 1'b0;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL busy_drop_last got=%b want=0", done);
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL reset_busy_len got=%0d want=16", n);
    end
    lookup(20'h20000, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b1, 8'h00, 22'h0}) begin
      bad++;
      $display("FAIL empty_miss got=%h want=%h", res, {1'b1, 1'b1, 8'h00, 22'h0});
    end
  endtask

  task automatic test_bare();
    logic [31:0] res;
    lookup(20'h12345, 1'b0, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'h00, 22'h012345}) begin
      bad++;
      $display("FAIL bare_pass got=%h want=%h", res, {1'b1, 1'b0, 8'h00, 22'h012345});
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_fill();
    logic [31:0] res;
    do_write(20'h20000, 8'hB1, 22'h10000);
    do_write(20'h20010, 8'hB3, 22'h10001);
    lookup(20'h20000, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB1, 22'h10000}) begin
      bad++;
      $display("FAIL fill_way0 got=%h want=%h", res, {1'b1, 1'b0, 8'hB1, 22'h10000});
    end
    lookup(20'h20010, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB3, 22'h10001}) begin
      bad++;
      $display("FAIL fill_way1 got=%h want=%h", res, {1'b1, 1'b0, 8'hB3, 22'h10001});
    end
    do_write(20'h20020, 8'hB5, 22'h10002);
    lookup(20'h20000, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b1, 8'h00, 22'h0}) begin
      bad++;
      $display("FAIL evict_old got=%h want=%h", res, {1'b1, 1'b1, 8'h00, 22'h0});
    end
    lookup(20'h20010, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB3, 22'h10001}) begin
      bad++;
      $display("FAIL evict_keep got=%h want=%h", res, {1'b1, 1'b0, 8'hB3, 22'h10001});
    end
  endtask

  task automatic test_update();
    logic [31:0] res;
    do_write(20'h20010, 8'hB7, 22'h30000);
    lookup(20'h20010, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB7, 22'h30000}) begin
      bad++;
      $display("FAIL update_inplace got=%h want=%h", res, {1'b1, 1'b0, 8'hB7, 22'h30000});
    end
    lookup(20'h20020, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB5, 22'h10002}) begin
      bad++;
      $display("FAIL update_other got=%h want=%h", res, {1'b1, 1'b0, 8'hB5, 22'h10002});
    end
  endtask

  task automatic test_inv_va();
    logic [31:0] res;
    virtual_address_w = 20'h20010;
    invalidate_va = 1'b1;
    tick();
    invalidate_va = 1'b0;
    lookup(20'h20010, 1'b1, res);
    total++;
    if (res[31:30] !== 2'b11) begin
      bad++;
      $display("FAIL inv_va_gone got=%b want=11", res[31:30]);
    end
    lookup(20'h20020, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hB5, 22'h10002}) begin
      bad++;
      $display("FAIL inv_va_keep got=%h want=%h", res, {1'b1, 1'b0, 8'hB5, 22'h10002});
    end
  endtask

  // Set 5: in-place update must not advance the victim pointer
  task automatic test_victim();
    logic [31:0] res;
    do_write(20'h40005, 8'hC0, 22'h00500);
    do_write(20'h40015, 8'hC1, 22'h00501);
    do_write(20'h40025, 8'hC2, 22'h00502);
    do_write(20'h40015, 8'hC3, 22'h00503);
    do_write(20'h40035, 8'hC4, 22'h00504);
    lookup(20'h40025, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hC2, 22'h00502}) begin
      bad++;
      $display("FAIL victim_keep got=%h want=%h", res, {1'b1, 1'b0, 8'hC2, 22'h00502});
    end
    lookup(20'h40015, 1'b1, res);
    total++;
    if (res[31:30] !== 2'b11) begin
      bad++;
      $display("FAIL victim_evict got=%b want=11", res[31:30]);
    end
    lookup(20'h40035, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hC4, 22'h00504}) begin
      bad++;
      $display("FAIL victim_new got=%h want=%h", res, {1'b1, 1'b0, 8'hC4, 22'h00504});
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [19:0] vas [5];
    int n;
    vas = '{20'h20000, 20'h20010, 20'h20020, 20'h40025, 20'h40035};
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    busy_len(6, n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL flush_len got=%0d want=16", n);
    end
    for (int i = 0; i < 5; i++) begin
      lookup(vas[i], 1'b1, res);
      total++;
      if (res !== {1'b1, 1'b1, 8'h00, 22'h0}) begin
        bad++;
        $display("FAIL flush_miss va=%h got=%h want=%h", vas[i], res, {1'b1, 1'b1, 8'h00, 22'h0});
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] res;
    int n;
    virtual_address_w = 20'h30003;
    accesstag_w = 8'hD1;
    phys_w = 22'h2ABCD;
    write = 1'b1;
    lookup(20'h30003, 1'b1, res);
    write = 1'b0;
    total++;
    if (res[31:30] !== 2'b11) begin
      bad++;
      $display("FAIL rbw_miss got=%b want=11", res[31:30]);
    end
    lookup(20'h30003, 1'b1, res);
    total++;
    if (res !== {1'b1, 1'b0, 8'hD1, 22'h2ABCD}) begin
      bad++;
      $display("FAIL rbw_hit got=%h want=%h", res, {1'b1, 1'b0, 8'hD1, 22'h2ABCD});
    end
    virtual_address_w = 20'h50007;
    write = 1'b1;
    invalidate = 1'b1;
    tick();
    write = 1'b0;
    invalidate = 1'b0;
    busy_len(0, n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL wr_inv_len got=%0d want=16", n);
    end
    lookup(20'h50007, 1'b1, res);
    total++;
    if (res[31:30] !== 2'b11) begin
      bad++;
      $display("FAIL wr_inv_dropped got=%b want=11", res[31:30]);
    end
  endtask

  task automatic test_rst_cases();
    int n;
    // reset cancels a lookup accepted in the same cycle
    enable = 1'b0;
    virtual_address = 20'h12345;
    resolve = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resolve = 1'b0;
    total++;
    if ({done, busy} !== 2'b01) begin
      bad++;
      $display("FAIL rst_cancel got=%b want=01", {done, busy});
    end
    busy_len(0, n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL rst_len got=%0d want=16", n);
    end
    // reset in the middle of a flush restarts it from set 0
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len(0, n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL rst_restart got=%0d want=16", n);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; resolve = 1'b0; write = 1'b0;
    invalidate = 1'b0; invalidate_va = 1'b0;
    virtual_address = '0; virtual_address_w = '0;
    accesstag_w = '0; phys_w = '0;
    tick();
    test_reset();
    test_bare();
    test_fill();
    test_update();
    test_inv_va();
    test_victim();
    test_flush();
    test_same_cycle();
    test_rst_cases();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
